// File: rtl/fb_scan_pkg.sv
// Shared types, defaults and colour helpers for the framebuffer scan generator.
package fb_scan_pkg;

    // Default 640x480 raster: the line event sits at the first blanking column.
    localparam int DEF_LINE_EVT = 640;
    localparam int DEF_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        MODE_GRAY     = 2'd0,
        MODE_RGB332   = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_RESERVED = 2'd3
    } pix_mode_t;

    // Per-pixel attributes that must travel alongside the memory read.
    typedef struct packed {
        logic      blank;
        logic      in_win;
        pix_mode_t mode;
        logic      row_lsb;
        logic      col_lsb;
    } pix_tag_t;

    // Expand RGB332 to 8:8:8 by replicating the high bits into the low bits.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6],
                d[4:2], d[4:2], d[4:3],
                {4{d[1:0]}}};
    endfunction

endpackage

// File: rtl/fb_scan_gen_pipe_delay.sv
// Fixed-depth shift register that keeps pixel attributes aligned with memory data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one position per clock; reset flushes every stage to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= sample;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/fb_scan_gen.sv
// Scaled framebuffer window on a raster: generates read addresses from the
// beam position and turns returned bytes into 24-bit pixels.
module fb_scan_gen
    import fb_scan_pkg::*;
#(
    parameter int  FB_W     = 64,
    parameter int  FB_H     = 64,
    parameter int  SCALE    = 7,
    parameter int  X_OFF    = 0,
    parameter int  Y_OFF    = 0,
    parameter int  MEM_LAT  = 1,
    parameter int  LINE_EVT = DEF_LINE_EVT,
    parameter int  V_ACTIVE = DEF_V_ACTIVE,
    localparam int ADDR_W   = $clog2(FB_W) + $clog2(FB_H)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              blank,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    input  logic [1:0]        mode,
    input  logic [23:0]       border,
    input  logic [7:0]        data,
    output logic [ADDR_W-1:0] addr,
    output logic [23:0]       rgb,
    output logic              frame_start
);

    localparam int COL_W = $clog2(FB_W);
    localparam int ROW_W = $clog2(FB_H);

    if (FB_W < 2 || (FB_W & (FB_W - 1)) != 0) begin : g_bad_fb_w
        $error("fb_scan_gen: FB_W must be a power of two");
    end
    if (FB_H < 2 || (FB_H & (FB_H - 1)) != 0) begin : g_bad_fb_h
        $error("fb_scan_gen: FB_H must be a power of two");
    end
    if (SCALE < 1 || SCALE > 15) begin : g_bad_scale
        $error("fb_scan_gen: SCALE must be 1..15");
    end
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("fb_scan_gen: MEM_LAT must be 1..4");
    end

    logic signed [31:0] x_rel, y_rel;
    logic               x_in, y_in, in_win, at_left;
    logic               line_evt, last_line, hsub_last;
    logic [3:0]         hsub, hsub_cur, vsub;
    logic [COL_W-1:0]   col, col_cur;
    logic [ROW_W-1:0]   row;
    pix_tag_t           tag_in, tag_out;

    assign x_rel     = $signed({22'd0, x_pos}) - X_OFF;
    assign y_rel     = $signed({22'd0, y_pos}) - Y_OFF;
    assign x_in      = (x_rel >= 0) && (x_rel < FB_W * SCALE);
    assign y_in      = (y_rel >= 0) && (y_rel < FB_H * SCALE);
    assign in_win    = x_in && y_in;
    assign at_left   = (x_rel == 0);
    assign line_evt  = (x_pos == 10'(LINE_EVT));
    assign last_line = (y_pos == 10'(V_ACTIVE - 1));

    // The left edge forces the horizontal position to zero for this very
    // pixel, so the first window pixel never depends on stale state.
    assign hsub_cur  = at_left ? '0 : hsub;
    assign col_cur   = at_left ? '0 : col;
    assign hsub_last = (hsub_cur == 4'(SCALE - 1));

    // Horizontal position: advance one screen pixel per clock inside the window.
    always_ff @(posedge clock) begin
        if (reset || !in_win) begin
            hsub <= '0;
            col  <= '0;
        end else if (hsub_last) begin
            hsub <= '0;
            col  <= col_cur + COL_W'(1);
        end else begin
            hsub <= hsub_cur + 4'd1;
            col  <= col_cur;
        end
    end

    // Vertical position: stepped once per line; the last row saturates until
    // the frame event so the bottom border cannot alias back to row 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            vsub <= '0;
            row  <= '0;
        end else if (line_evt) begin
            if (last_line) begin
                vsub <= '0;
                row  <= '0;
            end else if (y_in) begin
                if (vsub == 4'(SCALE - 1)) begin
                    vsub <= '0;
                    if (row != ROW_W'(FB_H - 1)) row <= row + ROW_W'(1);
                end else begin
                    vsub <= vsub + 4'd1;
                end
            end
        end
    end

    // Read address and frame marker, one clock after the position sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr        <= '0;
            frame_start <= 1'b0;
        end else begin
            addr        <= in_win ? {row, col_cur} : '0;
            frame_start <= line_evt && last_line;
        end
    end

    // Attributes of the sampled pixel, captured before the mode can change.
    always_comb begin
        tag_in         = '0;
        tag_in.blank   = blank;
        tag_in.in_win  = in_win;
        tag_in.mode    = pix_mode_t'(mode);
        tag_in.row_lsb = row[0];
        tag_in.col_lsb = col_cur[0];
    end

    pipe_delay #(
        .WIDTH ($bits(pix_tag_t)),
        .DEPTH (MEM_LAT + 1)
    ) u_tag_delay (
        .clock   (clock),
        .reset   (reset),
        .sample  (tag_in),
        .delayed (tag_out)
    );

    function automatic logic [23:0] pixel_colour(input pix_tag_t t,
                                                 input logic [7:0] d,
                                                 input logic [23:0] bcol);
        logic [23:0] c;
        c = '0;
        if (t.blank && !t.in_win) begin
            c = bcol;
        end else if (t.blank) begin
            case (t.mode)
                MODE_GRAY:    c = {3{d}};
                MODE_RGB332:  c = rgb332_expand(d);
                MODE_CHECKER: c = (t.row_lsb ^ t.col_lsb) ? 24'hFFFFFF : 24'h000000;
                default:      c = '0;
            endcase
        end
        return c;
    endfunction

    // Output pixel, registered when the memory byte for the tagged pixel arrives.
    always_ff @(posedge clock) begin
        if (reset) rgb <= '0;
        else       rgb <= pixel_colour(tag_out, data, border);
    end

endmodule

// File: tb/tb_fb_scan_gen.sv
// Directed bench for fb_scan_gen: default instance plus a MEM_LAT=3, SCALE=4,
// X_OFF=64 instance driven by the same raster, checked through a scoreboard.
module tb_fb_scan_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b0;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic [1:0]  mode  = '0;
    logic [23:0] border = 24'h123456;
    logic [7:0]  data_a, data_b;
    logic [11:0] addr_a, addr_b;
    logic [23:0] rgb_a, rgb_b;
    logic        fs_a, fs_b;

    logic [7:0]  mem [4096];
    logic [11:0] ap_a = '0;
    logic [11:0] ap_b [3] = '{12'd0, 12'd0, 12'd0};

    typedef struct {
        int          due;
        int          kind;
        int          dut;
        logic [23:0] exp;
    } chk_t;

    chk_t        sb [$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    int          ev [2] = '{0, 0};
    logic [23:0] obs;

    fb_scan_gen dut_a (
        .clock(clock), .reset(reset), .blank(blank), .x_pos(x_pos), .y_pos(y_pos),
        .mode(mode), .border(border), .data(data_a), .addr(addr_a), .rgb(rgb_a),
        .frame_start(fs_a)
    );

    fb_scan_gen #(.SCALE(4), .X_OFF(64), .MEM_LAT(3)) dut_b (
        .clock(clock), .reset(reset), .blank(blank), .x_pos(x_pos), .y_pos(y_pos),
        .mode(mode), .border(border), .data(data_b), .addr(addr_b), .rgb(rgb_b),
        .frame_start(fs_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Framebuffer memory models with one and three cycles of read latency.
    always @(posedge clock) begin
        ap_a    <= addr_a;
        ap_b[0] <= addr_b;
        ap_b[1] <= ap_b[0];
        ap_b[2] <= ap_b[1];
    end
    assign data_a = mem[ap_a];
    assign data_b = mem[ap_b[2]];

    function automatic string kind_name(input int k);
        return (k == 0) ? "addr" : (k == 1) ? "rgb" : "frame_start";
    endfunction

    function automatic logic [23:0] exp332(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

    // Drive one raster sample and queue what each instance must produce for it.
    task automatic pix(input int x, input int y, input logic b, input logic [1:0] m,
                       input logic r);
        int          sc, xo, ml, col, row, a;
        logic        win;
        logic [7:0]  dv;
        logic [23:0] c;
        @(negedge clock);
        x_pos = 10'(x);
        y_pos = 10'(y);
        blank = b;
        mode  = m;
        reset = r;
        for (int d = 0; d < 2; d++) begin
            sc  = (d == 0) ? 7 : 4;
            xo  = (d == 0) ? 0 : 64;
            ml  = (d == 0) ? 1 : 3;
            win = (x >= xo) && (x < xo + 64 * sc) && (y < 64 * sc);
            col = (x - xo) / sc;
            row = ev[d] / sc;
            if (row > 63) row = 63;
            a   = win ? row * 64 + col : 0;
            dv  = mem[a];
            if (r || !b)   c = 24'h000000;
            else if (!win) c = border;
            else begin
                case (m)
                    2'd0:    c = {dv, dv, dv};
                    2'd1:    c = exp332(dv);
                    2'd2:    c = (((row ^ col) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
                    default: c = 24'h000000;
                endcase
            end
            if (r) begin
                foreach (sb[i])
                    if (sb[i].dut == d && sb[i].kind == 1 && sb[i].due > cyc) sb[i].exp = '0;
            end
            sb.push_back('{due: cyc + 1, kind: 0, dut: d, exp: r ? 24'd0 : 24'(a)});
            sb.push_back('{due: cyc + 2 + ml, kind: 1, dut: d, exp: c});
            sb.push_back('{due: cyc + 1, kind: 2, dut: d,
                           exp: {23'd0, (!r && x == 640 && y == 479)}});
            if (r) ev[d] = 0;
            else if (x == 640) begin
                if (y == 479)         ev[d] = 0;
                else if (y < 64 * sc) ev[d] = ev[d] + 1;
            end
        end
    endtask

    // Scoreboard: compare every queued expectation on the cycle it falls due.
    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    0:       obs = (sb[i].dut == 0) ? {12'd0, addr_a} : {12'd0, addr_b};
                    1:       obs = (sb[i].dut == 0) ? rgb_a : rgb_b;
                    default: obs = (sb[i].dut == 0) ? {23'd0, fs_a} : {23'd0, fs_b};
                endcase
                checks++;
                assert (obs === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s dut%0d cycle %0d: observed %h expected %h",
                           kind_name(sb[i].kind), sb[i].dut, cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h5A ^ 8'(i);
        mem[2] = 8'hE3;

        repeat (4) pix(0, 0, 1'b0, 2'd0, 1'b1);

        // Line 0: gray, checker at col 1, RGB332 at col 2, reserved at col 3.
        for (int x = 0; x <= 70; x++)
            pix(x, 0, 1'b1,
                (x < 7) ? 2'd0 : (x < 14) ? 2'd2 : (x < 21) ? 2'd1 : (x < 28) ? 2'd3 : 2'd0,
                1'b0);
        pix(500, 0, 1'b1, 2'd0, 1'b0);
        pix(501, 0, 1'b0, 2'd0, 1'b0);
        pix(640, 0, 1'b0, 2'd0, 1'b0);

        for (int y = 1; y < 7; y++) begin
            pix(0, y, 1'b1, 2'd0, 1'b0);
            pix(640, y, 1'b0, 2'd0, 1'b0);
        end
        for (int x = 0; x <= 3; x++) pix(x, 7, 1'b1, 2'd0, 1'b0);
        pix(640, 7, 1'b0, 2'd0, 1'b0);

        for (int y = 8; y < 447; y++) begin
            pix(0, y, 1'b1, 2'd0, 1'b0);
            pix(640, y, 1'b0, 2'd0, 1'b0);
        end
        for (int x = 0; x <= 449; x++) pix(x, 447, 1'b1, 2'd0, 1'b0);
        pix(640, 447, 1'b0, 2'd0, 1'b0);

        for (int y = 448; y < 479; y++) pix(640, y, 1'b0, 2'd0, 1'b0);
        pix(0, 479, 1'b1, 2'd0, 1'b0);
        pix(640, 479, 1'b0, 2'd0, 1'b0);

        // Second frame, interrupted by a reset on line 200.
        for (int x = 0; x <= 3; x++) pix(x, 0, 1'b1, 2'd0, 1'b0);
        pix(640, 0, 1'b0, 2'd0, 1'b0);
        for (int y = 1; y < 200; y++) begin
            pix(0, y, 1'b1, 2'd0, 1'b0);
            pix(640, y, 1'b0, 2'd0, 1'b0);
        end
        for (int x = 0; x <= 10; x++) pix(x, 200, 1'b1, 2'd2, 1'b0);
        pix(11, 200, 1'b1, 2'd0, 1'b1);
        pix(12, 200, 1'b1, 2'd0, 1'b1);
        pix(640, 200, 1'b0, 2'd0, 1'b0);
        for (int y = 201; y < 479; y++) begin
            pix(0, y, 1'b1, 2'd0, 1'b0);
            pix(640, y, 1'b0, 2'd0, 1'b0);
        end
        pix(640, 479, 1'b0, 2'd0, 1'b0);

        // Third frame starts cleanly at the origin.
        for (int x = 0; x <= 3; x++) pix(x, 0, 1'b1, 2'd0, 1'b0);
        repeat (3) pix(700, 1, 1'b0, 2'd0, 1'b0);

        repeat (8) @(negedge clock);
        @(posedge clock);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expectations expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
